// File: rtl/udlx_trace_pkg.sv
// Shared types for the UDLX bus trace monitor: trace entry layout, FSM states
// and the saturating drop-counter helper.
package udlx_trace_pkg;

    localparam int DROP_CNT_W   = 16;

    // Entry field widths; these match the monitor's default parameters and
    // must be widened together with them.
    localparam int TRACE_CH_W   = 2;
    localparam int TRACE_TS_W   = 16;
    localparam int TRACE_ADDR_W = 32;
    localparam int TRACE_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_CH_W-1:0]   ch;
        logic                    wr;
        logic [TRACE_TS_W-1:0]   ts;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

    // Add up to 15 lost accesses to the drop counter, sticking at all-ones.
    function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [3:0]            inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_CNT_W-3){1'b0}}, inc};
        if (sum[DROP_CNT_W]) begin
            return '1;
        end else begin
            return sum[DROP_CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/udlx_trace_fifo.sv
// Show-ahead trace FIFO. A push while full without a pop overwrites the
// oldest entry; the caller decides whether such a push is allowed.
module udlx_trace_fifo
    import udlx_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  trace_entry_t     data_i,
    output trace_entry_t     head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    trace_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             do_pop_s;

    assign valid_o  = (cnt_q != '0);
    assign full_o   = (cnt_q == LVL_W'(DEPTH));
    assign do_pop_s = pop_i & valid_o;
    assign level_o  = cnt_q;
    // Stale storage is never visible: the head reads as zero when empty.
    assign head_o   = valid_o ? mem_q[rd_q] : '0;

    // Pointer and occupancy next state, including the overwrite-oldest case.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop_s || (push_i && full_o)) begin
                rd_d = rd_q + PTR_W'(1);
            end else begin
                rd_d = rd_q;
            end
            if (push_i) begin
                wr_d = wr_q + PTR_W'(1);
            end else begin
                wr_d = wr_q;
            end
            if (push_i && !do_pop_s && !full_o) begin
                cnt_d = cnt_q + LVL_W'(1);
            end else if (do_pop_s && !push_i) begin
                cnt_d = cnt_q - LVL_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are masked by the occupancy count, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/udlx_trace_monitor.sv
// Multi-channel bus trace monitor: per-channel holding registers, round-robin
// arbitration into the trace FIFO, timestamping, drop accounting and the
// IDLE/CAPTURE/FROZEN capture FSM.
module udlx_trace_monitor
    import udlx_trace_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int TS_WIDTH   = 16,
    parameter  int DEPTH      = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH-1:0]            ch_wr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic                         cfg_enable,
    input  logic                         cfg_wrap,
    input  logic                         clear,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [CH_W-1:0]              trace_ch,
    output logic                         trace_wr,
    output logic [TS_WIDTH-1:0]          trace_ts,
    output logic [ADDR_WIDTH-1:0]        trace_addr,
    output logic [DATA_WIDTH-1:0]        trace_data,
    output logic [LVL_W-1:0]             fifo_level,
    output logic                         frozen,
    output logic [DROP_CNT_W-1:0]        drop_count
);

    trace_state_e          state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [NUM_CH-1:0]     hold_vld_q, hold_vld_d, hold_drop_s, grant_oh_s;
    trace_entry_t          hold_q [NUM_CH];
    trace_entry_t          hold_d [NUM_CH];
    logic [CH_W-1:0]       rr_q, rr_d, grant_idx_s, cand_s;
    logic                  grant_vld_s;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [3:0]            drop_inc_s;
    logic                  frozen_q;
    logic                  pop_s, push_s, fifo_full_s, fifo_valid_s;
    logic                  fifo_drop_s, freeze_evt_s;
    trace_entry_t          head_s;
    logic [LVL_W-1:0]      level_s;

    // Pick one occupied holding register, searching from the last grant + 1.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_s = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (!grant_vld_s && hold_vld_q[cand_s] && (state_q != ST_FROZEN)) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        grant_oh_s = '0;
        if (grant_vld_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
    end

    // FIFO handshake: a full FIFO without a pop loses the push unless wrapping.
    assign pop_s        = fifo_valid_s & trace_ready & ~clear;
    assign fifo_drop_s  = grant_vld_s & fifo_full_s & ~pop_s;
    assign push_s       = grant_vld_s & ~clear & (~fifo_full_s | pop_s | cfg_wrap);
    assign freeze_evt_s = fifo_drop_s & ~cfg_wrap & (state_q == ST_CAPTURE);

    // Holding registers: drain the granted one, then load new accesses in CAPTURE.
    always_comb begin
        hold_vld_d  = hold_vld_q & ~grant_oh_s;
        hold_d      = hold_q;
        hold_drop_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state_q == ST_CAPTURE) && ch_valid[i]) begin
                if (hold_vld_d[i]) begin
                    hold_drop_s[i] = 1'b1;
                end else begin
                    hold_vld_d[i]   = 1'b1;
                    hold_d[i].ch    = TRACE_CH_W'(i);
                    hold_d[i].wr    = ch_wr[i];
                    hold_d[i].ts    = TRACE_TS_W'(ts_q);
                    hold_d[i].addr  = TRACE_ADDR_W'(ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
                    hold_d[i].data  = TRACE_DATA_W'(ch_data[i*DATA_WIDTH +: DATA_WIDTH]);
                end
            end else begin
                hold_drop_s[i] = 1'b0;
            end
        end
        if (clear || (state_q == ST_FROZEN)) begin
            hold_vld_d = '0;
        end else begin
            hold_vld_d = hold_vld_d;
        end
    end

    // Lost accesses this cycle: holding-register collisions plus a FIFO loss.
    always_comb begin
        drop_inc_s = {3'b000, fifo_drop_s};
        for (int i = 0; i < NUM_CH; i++) begin
            drop_inc_s = drop_inc_s + {3'b000, hold_drop_s[i]};
        end
        if (clear) begin
            drop_d = '0;
        end else begin
            drop_d = drop_sat_add(drop_q, drop_inc_s);
        end
    end

    // Capture FSM; clear re-enters IDLE or CAPTURE from any state.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = cfg_enable ? ST_CAPTURE : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = cfg_enable ? ST_CAPTURE : ST_IDLE;
                ST_CAPTURE: begin
                    if (freeze_evt_s) begin
                        state_d = ST_FROZEN;
                    end else if (!cfg_enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_FROZEN:  state_d = ST_FROZEN;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Timestamp runs outside IDLE; arbiter pointer follows the last grant.
    always_comb begin
        ts_d = ts_q;
        rr_d = rr_q;
        if (clear) begin
            ts_d = '0;
            rr_d = CH_W'(NUM_CH - 1);
        end else begin
            if (state_q != ST_IDLE) begin
                ts_d = ts_q + TS_WIDTH'(1);
            end else begin
                ts_d = ts_q;
            end
            if (grant_vld_s) begin
                rr_d = grant_idx_s;
            end else begin
                rr_d = rr_q;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            rr_q       <= CH_W'(NUM_CH - 1);
            drop_q     <= '0;
            frozen_q   <= 1'b0;
            hold_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            rr_q       <= rr_d;
            drop_q     <= drop_d;
            frozen_q   <= (state_d == ST_FROZEN);
            hold_vld_q <= hold_vld_d;
        end
    end

    // Holding register payloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '{default: '0};
        end else begin
            hold_q <= hold_d;
        end
    end

    udlx_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (hold_q[grant_idx_s]),
        .head_o  (head_s),
        .valid_o (fifo_valid_s),
        .full_o  (fifo_full_s),
        .level_o (level_s)
    );

    assign trace_valid = fifo_valid_s;
    assign trace_ch    = CH_W'(head_s.ch);
    assign trace_wr    = head_s.wr;
    assign trace_ts    = TS_WIDTH'(head_s.ts);
    assign trace_addr  = ADDR_WIDTH'(head_s.addr);
    assign trace_data  = DATA_WIDTH'(head_s.data);
    assign fifo_level  = level_s;
    assign frozen      = frozen_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_udlx_trace_monitor.sv
// Self-checking bench for udlx_trace_monitor: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_udlx_trace_monitor;

    localparam int NUM_CH = 4;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TSW    = 16;
    localparam int DEPTH  = 16;
    localparam int CHW    = 2;
    localparam int LW     = 5;

    localparam int M_IDLE = 0;
    localparam int M_CAP  = 1;
    localparam int M_FRZ  = 2;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           wr;
        logic [TSW-1:0] ts;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    ch_valid, ch_wr;
    logic [NUM_CH*AW-1:0] ch_addr;
    logic [NUM_CH*DW-1:0] ch_data;
    logic                 cfg_enable, cfg_wrap, clear, trace_ready;
    logic                 trace_valid, trace_wr, frozen;
    logic [CHW-1:0]       trace_ch;
    logic [TSW-1:0]       trace_ts;
    logic [AW-1:0]        trace_addr;
    logic [DW-1:0]        trace_data;
    logic [LW-1:0]        fifo_level;
    logic [15:0]          drop_count;

    udlx_trace_monitor dut (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_wr(ch_wr),
        .ch_addr(ch_addr), .ch_data(ch_data), .cfg_enable(cfg_enable),
        .cfg_wrap(cfg_wrap), .clear(clear), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_ch(trace_ch), .trace_wr(trace_wr),
        .trace_ts(trace_ts), .trace_addr(trace_addr), .trace_data(trace_data),
        .fifo_level(fifo_level), .frozen(frozen), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int   err_cnt   = 0;
    int   check_cnt = 0;

    // reference model state
    ent_t q[$];
    ent_t hold[NUM_CH];
    bit   hv[NUM_CH];
    int   mst, mts, mrr, mdrop;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            hv[i]   = 1'b0;
            hold[i] = '0;
        end
        mst = M_IDLE; mts = 0; mrr = NUM_CH - 1; mdrop = 0;
    endtask

    // One clock of the monitor's behaviour, computed from the current inputs.
    task automatic model_eval();
        int   g, inc;
        bit   pop, frz;
        ent_t ge;
        pop = (q.size() > 0) && trace_ready;
        if (clear) begin
            q.delete();
            for (int i = 0; i < NUM_CH; i++) hv[i] = 1'b0;
            mts = 0; mdrop = 0; mrr = NUM_CH - 1;
            mst = cfg_enable ? M_CAP : M_IDLE;
            return;
        end
        g = -1; inc = 0; frz = 1'b0; ge = '0;
        if (mst != M_FRZ) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (mrr + k) % NUM_CH;
                if (g < 0 && hv[c]) g = c;
            end
        end
        if (g >= 0) begin
            ge    = hold[g];
            hv[g] = 1'b0;
        end
        if (mst == M_FRZ) begin
            for (int i = 0; i < NUM_CH; i++) hv[i] = 1'b0;
        end
        if (mst == M_CAP) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i]) begin
                    if (hv[i]) inc++;
                    else begin
                        hv[i]   = 1'b1;
                        hold[i] = '{ch: CHW'(i), wr: ch_wr[i], ts: TSW'(mts),
                                    addr: ch_addr[i*AW +: AW], data: ch_data[i*DW +: DW]};
                    end
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (g >= 0) begin
            if (q.size() < DEPTH) q.push_back(ge);
            else begin
                inc++;
                if (cfg_wrap) begin
                    void'(q.pop_front());
                    q.push_back(ge);
                end else if (mst == M_CAP) frz = 1'b1;
            end
        end
        if (mst != M_IDLE) mts = (mts + 1) % 65536;
        if (mst == M_IDLE) mst = cfg_enable ? M_CAP : M_IDLE;
        else if (mst == M_CAP) mst = frz ? M_FRZ : (cfg_enable ? M_CAP : M_IDLE);
        mdrop = (mdrop + inc > 65535) ? 65535 : mdrop + inc;
        if (g >= 0) mrr = g;
    endtask

    task automatic compare();
        ent_t e;
        e = (q.size() > 0) ? q[0] : '0;
        chk("valid",  trace_valid, (q.size() > 0));
        chk("head",   {trace_ch, trace_wr, trace_ts, trace_addr, trace_data}, e);
        chk("level",  fifo_level, q.size());
        chk("frozen", frozen, (mst == M_FRZ));
        chk("drop",   drop_count, mdrop);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_ch(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        ch_valid[i]          = 1'b1;
        ch_wr[i]             = wr;
        ch_addr[i*AW +: AW]  = a;
        ch_data[i*DW +: DW]  = d;
    endtask

    task automatic clr_ch();
        ch_valid = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare();
        @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;
    endtask

    task automatic random_cycles(input int n, input int rd_pct);
        for (int c = 0; c < n; c++) begin
            ch_valid    = NUM_CH'($urandom) & NUM_CH'($urandom);
            ch_wr       = NUM_CH'($urandom);
            ch_addr     = {$urandom, $urandom, $urandom, $urandom};
            ch_data     = {$urandom, $urandom, $urandom, $urandom};
            trace_ready = ($urandom_range(0, 9) < rd_pct);
            if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 59) == 0) cfg_wrap = ~cfg_wrap;
            clear = ($urandom_range(0, 149) == 0);
            step();
        end
        clear = 1'b0;
        clr_ch();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ch_valid = '0; ch_wr = '0; ch_addr = '0; ch_data = '0;
        cfg_enable = 1'b0; cfg_wrap = 1'b0; clear = 1'b0; trace_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;

        // single channel-1 write captured at timestamp 5
        cfg_enable = 1'b1;
        step();
        for (int n = 0; n < 20 && mts != 5; n++) step();
        set_ch(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        step();
        clr_ch();
        chk("t1_early", trace_valid, 1'b0);
        step();
        chk("t1_valid", trace_valid, 1'b1);
        chk("t1_ch",    trace_ch, 2'd1);
        chk("t1_wr",    trace_wr, 1'b1);
        chk("t1_ts",    trace_ts, 16'd5);
        chk("t1_addr",  trace_addr, 32'h0000_0100);
        chk("t1_data",  trace_data, 32'hDEAD_BEEF);

        // all channels in one cycle: ordered ch0..ch3, same timestamp
        do_clear();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, i[0], 32'h1000 + 32'(i), 32'hA000 + 32'(i));
        step();
        clr_ch();
        repeat (4) step();
        chk("t2_level", fifo_level, 5'd4);
        trace_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            chk("t2_ch", trace_ch, k);
            chk("t2_ts", trace_ts, 16'd0);
            step();
        end
        trace_ready = 1'b0;

        // wrap mode: 20 accesses into 16 entries
        cfg_wrap = 1'b1;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            set_ch(0, 1'b0, 32'(i), ~32'(i));
            step();
        end
        clr_ch();
        step();
        chk("t3_level", fifo_level, 5'd16);
        chk("t3_drop",  drop_count, 16'd4);
        chk("t3_head",  trace_addr, 32'd4);

        // freeze mode: 17th access freezes, later accesses ignored, clear recovers
        cfg_wrap = 1'b0;
        do_clear();
        for (int i = 0; i < 17; i++) begin
            set_ch(0, 1'b1, 32'h2000 + 32'(i), 32'(i));
            step();
        end
        clr_ch();
        step();
        chk("t4_frozen", frozen, 1'b1);
        chk("t4_drop",   drop_count, 16'd1);
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, 32'h3000, 32'h0);
            step();
        end
        clr_ch();
        step();
        chk("t4_drop_hold", drop_count, 16'd1);
        chk("t4_level",     fifo_level, 5'd16);
        do_clear();
        chk("t4_unfrozen", frozen, 1'b0);
        chk("t4_cleared",  fifo_level, 5'd0);
        chk("t4_drop_clr", drop_count, 16'd0);

        // all channels continuous with draining reader: 3 collisions per cycle
        trace_ready = 1'b1;
        do_clear();
        for (int n = 0; n < 20; n++) begin
            for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, 32'h4000 + 32'(n), 32'(c));
            step();
        end
        chk("t5_drop", drop_count, 16'd57);
        clr_ch();
        repeat (6) step();

        // full FIFO, reader stalls then pops in the same cycle as a push
        trace_ready = 1'b0;
        do_clear();
        for (int i = 0; i < 16; i++) begin
            set_ch(0, 1'b0, 32'h6000 + 32'(i), 32'(i));
            step();
        end
        clr_ch();
        step();
        chk("t6_full", fifo_level, 5'd16);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_stable", trace_addr, 32'h6000);
        end
        set_ch(0, 1'b0, 32'h6010, 32'h10);
        step();
        clr_ch();
        trace_ready = 1'b1;
        step();
        chk("t6_nodrop", drop_count, 16'd0);
        chk("t6_level",  fifo_level, 5'd16);
        chk("t6_frozen", frozen, 1'b0);
        chk("t6_head",   trace_addr, 32'h6001);
        trace_ready = 1'b0;

        // random traffic with varying reader pressure, reset mid-capture
        cfg_enable = 1'b1;
        do_clear();
        random_cycles(300, 3);
        do_reset();
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_level", fifo_level, 5'd0);
        cfg_enable = 1'b1;
        random_cycles(300, 8);
        random_cycles(300, 5);

        // drop counter saturation
        cfg_enable = 1'b1;
        cfg_wrap = 1'b1;
        trace_ready = 1'b0;
        do_clear();
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 32'h7000, 32'h0);
        for (int n = 0; n < 16600; n++) step();
        chk("sat_drop", drop_count, 16'hFFFF);
        clr_ch();

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/udlx_trace_monitor.md
# udlx_trace_monitor

Synthesizable multi-channel bus trace monitor for the UDLX processor. Taps up to `NUM_CH` memory-access channels (instruction fetch, data read, data write, SDRAM controller requests), timestamps each access, and queues entries in an on-chip trace FIFO that a debug host drains through a valid/ready port. Sits beside `dlx_processor` inside `top` and replaces hierarchical-probe monitoring in silicon and FPGA builds.

## Interface
- `NUM_CH`, 4, number of monitored channels (1..8)
- `ADDR_WIDTH`, 32, captured address width
- `DATA_WIDTH`, 32, captured data width
- `TS_WIDTH`, 16, timestamp counter width
- `DEPTH`, 16, trace FIFO entries (power of two, ≥2)

Ports:
- `clk` in 1: single clock; one clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ch_valid` in NUM_CH: per-channel access strobe, one cycle per access.
- `ch_wr` in NUM_CH: 1 = write, 0 = read.
- `ch_addr` in NUM_CH*ADDR_WIDTH: packed addresses, channel 0 in LSBs.
- `ch_data` in NUM_CH*DATA_WIDTH: packed data, channel 0 in LSBs.
- `cfg_enable` in 1: capture enable.
- `cfg_wrap` in 1: 1 = overwrite oldest when full, 0 = freeze when full.
- `clear` in 1: synchronous flush.
- `trace_valid` out 1; `trace_ready` in 1: output handshake.
- `trace_ch` out $clog2(NUM_CH) (min 1); `trace_wr` out 1; `trace_ts` out TS_WIDTH; `trace_addr` out ADDR_WIDTH; `trace_data` out DATA_WIDTH: head entry.
- `fifo_level` out $clog2(DEPTH)+1: occupied entries.
- `frozen` out 1: capture stopped by full FIFO.
- `drop_count` out 16: lost accesses, saturating at 0xFFFF.

## Operation
- States: `IDLE` (cfg_enable=0), `CAPTURE`, `FROZEN`. IDLE→CAPTURE when cfg_enable=1; CAPTURE→IDLE when cfg_enable=0; CAPTURE→FROZEN when FIFO full, cfg_wrap=0, and a push is requested; FROZEN→IDLE/CAPTURE only on `clear` (per cfg_enable). Reading still works in FROZEN.
- Timestamp counter increments every cycle outside IDLE, wraps modulo 2^TS_WIDTH; holds in IDLE.
- Per-channel one-entry holding register: in CAPTURE, `ch_valid` loads {wr, addr, data, current ts}. Valid while holding register occupied and not draining this cycle → access dropped, `drop_count`+1.
- Round-robin arbiter: one occupied holding register pushed into FIFO per cycle, search starts at last-granted+1; pointer resets to NUM_CH-1 (channel 0 first). Holding register freed and reloaded in the same cycle is legal.
- FIFO full, push requested, no pop: wrap mode → oldest discarded, new pushed, `drop_count`+1; freeze mode → push discarded, `drop_count`+1, enter FROZEN. Full with pop same cycle → both happen, no drop.
- In IDLE and FROZEN, `ch_valid` ignored (no drop count); pending holding registers still drain in IDLE, are discarded in FROZEN.
- `clear`: empties FIFO and holding registers, zeros timestamp and `drop_count`, resets arbiter pointer; wins over all simultaneous events.

## Timing
- Reset values: `trace_valid`=0, all trace fields 0, `fifo_level`=0, `frozen`=0, `drop_count`=0, state IDLE, timestamp 0.
- Latency: access at edge N → holding reg at N, FIFO write at N+1, `trace_valid` high after N+1 (show-ahead head).
- Pop on `trace_valid && trace_ready`; head fields stable while `trace_valid && !trace_ready`.
- `fifo_level`, `frozen`, `drop_count` registered; update one cycle after the causing event.
- Reset mid-capture: all contents lost, no partial entry emitted.

## Structure
- Package `udlx_trace_pkg`: `trace_entry_t` struct (ch, wr, ts, addr, data), `trace_state_e` enum, `DROP_CNT_W`=16.
- Sub-module `udlx_trace_fifo`: show-ahead synchronous FIFO with overwrite-oldest input, level output. Arbiter, holding registers, FSM, counters in top module.

## Test plan
- Reset, cfg_enable=1, single channel-1 write addr 0x100 data 0xDEADBEEF at ts 5 → entry {ch=1, wr=1, ts=5, addr=0x100} with trace_valid two cycles later.
- All 4 channels valid in one cycle → four entries ordered ch0,1,2,3, consecutive ts equal, fifo_level 4.
- cfg_wrap=1, DEPTH=16, 20 accesses, no reads → level 16, drop_count 4, head is 5th access.
- cfg_wrap=0, 17 accesses → frozen=1, drop_count 1, further valid ignored; clear → frozen=0, level 0, drop_count 0.
- Channel 0 valid every cycle with channels 1–3 also continuous → round-robin grants, channel 0 drops counted exactly.
- trace_ready held low 3 cycles then high while full with push → head stable, simultaneous push/pop causes no drop.
